// File: rtl/ntt_pkg.sv
// Shared NTT helpers: reduction-stage count, multiplier latency, and the
// running-sum width at each Montgomery word-reduction stage.
package ntt_pkg;

    // Number of W-bit reduction digits needed to cover a LOGQ-bit modulus.
    function automatic int unsigned num_words(input int unsigned logq, input int unsigned w);
        return (logq + w - 1) / w;
    endfunction

    // Total latency of btf_montmul: input reg, product reg, L reductions, final subtract.
    function automatic int unsigned btf_montmul_lat(input int unsigned logq, input int unsigned w);
        return num_words(logq, w) + 3;
    endfunction

    // Width of the running sum entering reduction stage k (k = 0 is the raw product).
    // After k steps T < q^2/2^(k*w) + q, so the width shrinks by w per stage until
    // it bottoms out at logq+1 bits (T < 2q).
    function automatic int unsigned red_width(input int unsigned logq, input int unsigned w,
                                              input int unsigned k);
        int unsigned shrink;
        if (k == 0) return 2 * logq;
        shrink = k * w;
        if (shrink + logq >= 2 * logq) return logq + 1;
        return 2 * logq - shrink + 1;
    endfunction

endpackage

// File: rtl/mont_word_red.sv
// One registered Montgomery word-reduction step for moduli with q = 1 mod 2^W.
// Computes (T + m*q) >> W with m = -T mod 2^W, without any wide low-word adder.
module mont_word_red
    import ntt_pkg::*;
#(
    parameter int unsigned LOGQ      = 8,
    parameter int unsigned WORD_SIZE = 4,
    parameter int unsigned TIW       = 16,
    parameter int unsigned TOW       = 13
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [LOGQ-WORD_SIZE-1:0] qh,
    input  logic [TIW-1:0]            t_in,
    output logic [TOW-1:0]            t_out
);

    logic [WORD_SIZE-1:0] t_lo;
    logic [WORD_SIZE-1:0] m;
    logic [LOGQ-1:0]      mq_hi;
    logic [TOW-1:0]       t_next;

    // m*q = (m*qh)<<W + m; the low word T_lo + m is either 0 (T_lo = 0) or
    // exactly 2^W, so after the shift it contributes only a carry of (T_lo != 0).
    always_comb begin
        t_lo   = t_in[WORD_SIZE-1:0];
        m      = -t_lo;
        mq_hi  = LOGQ'(m) * LOGQ'(qh);
        t_next = TOW'(t_in[TIW-1:WORD_SIZE]) + TOW'(mq_hi) + TOW'(t_lo != '0);
    end

    // Stage register: reset clears, en advances, otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            t_out <= '0;
        end else if (en) begin
            t_out <= t_next;
        end
    end

endmodule

// File: rtl/btf_montmul.sv
// Pipelined Montgomery twiddle multiplier for the NTT butterfly:
// bw_o = b*w*R^-1 mod q, with a and valid delayed to match (latency L+3).
module btf_montmul
    import ntt_pkg::*;
#(
    parameter int unsigned     LOGQ      = 8,
    parameter logic [LOGQ-1:0] Q_VALUE   = '0,
    parameter int unsigned     WORD_SIZE = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [LOGQ-WORD_SIZE-1:0] qH,
    input  logic                      valid_i,
    input  logic [LOGQ-1:0]           a,
    input  logic [LOGQ-1:0]           b,
    input  logic [LOGQ-1:0]           w,
    output logic                      valid_o,
    output logic [LOGQ-1:0]           a_o,
    output logic [LOGQ-1:0]           bw_o
);

    localparam int unsigned L       = num_words(LOGQ, WORD_SIZE);
    localparam int unsigned QHW     = LOGQ - WORD_SIZE;
    localparam int unsigned TW0     = 2 * LOGQ;
    localparam bit          Q_CONST = (Q_VALUE != '0);

    logic [QHW-1:0]  qh_sel;
    logic [LOGQ-1:0] q_sel;

    logic [LOGQ-1:0] a_s0, b_s0, w_s0, a_s1;
    logic            v_s0, v_s1;
    logic [TW0-1:0]  t0;
    logic [LOGQ-1:0] a_d [L];
    logic            v_d [L];
    logic [LOGQ:0]   t_fin;
    logic [LOGQ-1:0] t_sub;
    logic [LOGQ-1:0] bw_next;

    // Modulus selection: compile-time constant, or runtime {qH, 0..01}.
    always_comb begin
        qh_sel = Q_CONST ? Q_VALUE[LOGQ-1:WORD_SIZE] : qH;
        q_sel  = Q_CONST ? Q_VALUE : {qH, WORD_SIZE'(1)};
    end

    // Input capture (S0) and full-width product (S1).
    always_ff @(posedge clk) begin
        if (rst) begin
            a_s0 <= '0;
            b_s0 <= '0;
            w_s0 <= '0;
            v_s0 <= 1'b0;
            a_s1 <= '0;
            v_s1 <= 1'b0;
            t0   <= '0;
        end else if (en) begin
            a_s0 <= a;
            b_s0 <= b;
            w_s0 <= w;
            v_s0 <= valid_i;
            a_s1 <= a_s0;
            v_s1 <= v_s0;
            t0   <= TW0'(b_s0) * TW0'(w_s0);
        end
    end

    // Delay a and valid alongside the L reduction stages.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < L; i++) begin
                a_d[i] <= '0;
                v_d[i] <= 1'b0;
            end
        end else if (en) begin
            a_d[0] <= a_s1;
            v_d[0] <= v_s1;
            for (int unsigned i = 1; i < L; i++) begin
                a_d[i] <= a_d[i-1];
                v_d[i] <= v_d[i-1];
            end
        end
    end

    // Reduction chain; each stage's width is sized to the bound on T at that point.
    for (genvar k = 0; k < L; k++) begin : g_red
        localparam int unsigned TIW = red_width(LOGQ, WORD_SIZE, k);
        localparam int unsigned TOW = red_width(LOGQ, WORD_SIZE, k + 1);
        logic [TIW-1:0] t_in;
        logic [TOW-1:0] t_out;
        if (k == 0) begin : g_first
            assign t_in = t0;
        end else begin : g_next
            assign t_in = g_red[k-1].t_out;
        end
        mont_word_red #(
            .LOGQ      (LOGQ),
            .WORD_SIZE (WORD_SIZE),
            .TIW       (TIW),
            .TOW       (TOW)
        ) u_red (
            .clk   (clk),
            .rst   (rst),
            .en    (en),
            .qh    (qh_sel),
            .t_in  (t_in),
            .t_out (t_out)
        );
    end

    assign t_fin = g_red[L-1].t_out;

    // Final conditional subtraction; T < 2q so one subtract fully reduces.
    always_comb begin
        t_sub   = t_fin[LOGQ-1:0] - q_sel;
        bw_next = (t_fin >= {1'b0, q_sel}) ? t_sub : t_fin[LOGQ-1:0];
    end

    // Output stage (SF).
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_o <= 1'b0;
            a_o     <= '0;
            bw_o    <= '0;
        end else if (en) begin
            valid_o <= v_d[L-1];
            a_o     <= a_d[L-1];
            bw_o    <= bw_next;
        end
    end

endmodule

// File: tb/tb_btf_montmul.sv
// Directed bench for btf_montmul with q = 17, W = 4 (L = 2, LAT = 5, R = 256 = 1 mod 17),
// exercising both the constant-q and runtime-q (qH = 1) configurations.
module tb_btf_montmul;

    logic       clk = 1'b0;
    logic       rst, en, valid_i;
    logic [3:0] qh, qh_junk;
    logic [7:0] a, b, w;
    logic       vc, vr;
    logic [7:0] ac, ar, bwc, bwr;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    btf_montmul #(.LOGQ(8), .Q_VALUE(8'd17), .WORD_SIZE(4)) dut_c (
        .clk(clk), .rst(rst), .en(en), .qH(qh_junk), .valid_i(valid_i),
        .a(a), .b(b), .w(w), .valid_o(vc), .a_o(ac), .bw_o(bwc)
    );

    btf_montmul #(.LOGQ(8), .Q_VALUE(8'd0), .WORD_SIZE(4)) dut_r (
        .clk(clk), .rst(rst), .en(en), .qH(qh), .valid_i(valid_i),
        .a(a), .b(b), .w(w), .valid_o(vr), .a_o(ar), .bw_o(bwr)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] bb, input logic [7:0] ww, input logic [7:0] aa);
        valid_i = v; b = bb; w = ww; a = aa;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; drive(1'b0, 8'd0, 8'd0, 8'd0);
        step(); step();
        checks++; if (vc !== 1'b0)  begin errors++; $display("FAIL reset_valid_c got=%b want=0", vc); end
        checks++; if (ac !== 8'd0)  begin errors++; $display("FAIL reset_a_c got=%0d want=0", ac); end
        checks++; if (bwc !== 8'd0) begin errors++; $display("FAIL reset_bw_c got=%0d want=0", bwc); end
        checks++; if (vr !== 1'b0)  begin errors++; $display("FAIL reset_valid_r got=%b want=0", vr); end
        checks++; if (bwr !== 8'd0) begin errors++; $display("FAIL reset_bw_r got=%0d want=0", bwr); end
        rst = 1'b0; en = 1'b1;
    endtask

    task automatic test_basic();
        drive(1'b1, 8'd3, 8'd5, 8'd9);
        step();
        drive(1'b0, 8'd0, 8'd0, 8'd0);
        for (int c = 2; c <= 6; c++) begin
            step();
            checks++;
            if (vc !== (c == 5)) begin errors++; $display("FAIL basic_valid cyc=%0d got=%b want=%b", c, vc, (c == 5)); end
            if (c == 5) begin
                checks++; if (bwc !== 8'd15) begin errors++; $display("FAIL basic_bw got=%0d want=15", bwc); end
                checks++; if (ac !== 8'd9)   begin errors++; $display("FAIL basic_a got=%0d want=9", ac); end
            end
        end
    endtask

    task automatic test_edges();
        drive(1'b1, 8'd16, 8'd16, 8'd1);  step();
        drive(1'b1, 8'd0,  8'd7,  8'd16); step();
        drive(1'b0, 8'd0,  8'd0,  8'd0);
        step(); step(); step();
        checks++; if (vc !== 1'b1)  begin errors++; $display("FAIL edge16_valid got=%b want=1", vc); end
        checks++; if (bwc !== 8'd1) begin errors++; $display("FAIL edge16_bw got=%0d want=1", bwc); end
        checks++; if (ac !== 8'd1)  begin errors++; $display("FAIL edge16_a got=%0d want=1", ac); end
        step();
        checks++; if (vc !== 1'b1)  begin errors++; $display("FAIL edge0_valid got=%b want=1", vc); end
        checks++; if (bwc !== 8'd0) begin errors++; $display("FAIL edge0_bw got=%0d want=0", bwc); end
        checks++; if (ac !== 8'd16) begin errors++; $display("FAIL edge0_a got=%0d want=16", ac); end
        step();
        checks++; if (vc !== 1'b0)  begin errors++; $display("FAIL edge_tail_valid got=%b want=0", vc); end
    endtask

    task automatic test_back_to_back();
        int idx;
        for (int c = 1; c <= 25; c++) begin
            if (c <= 17) drive(1'b1, 8'(c - 1), 8'(c - 1), 8'(c - 1));
            else         drive(1'b0, 8'd0, 8'd0, 8'd0);
            step();
            idx = c - 5;
            checks++;
            if (vc !== (c >= 5 && c <= 21)) begin
                errors++; $display("FAIL b2b_valid cyc=%0d got=%b want=%b", c, vc, (c >= 5 && c <= 21));
            end
            if (c >= 5 && c <= 21) begin
                checks++;
                if (bwc !== 8'((idx * idx) % 17) || ac !== 8'(idx)) begin
                    errors++; $display("FAIL b2b_data i=%0d got bw=%0d a=%0d want bw=%0d a=%0d",
                                       idx, bwc, ac, (idx * idx) % 17, idx);
                end
            end
        end
    endtask

    task automatic test_stall();
        int sb [5];
        int sw [5];
        int idx;
        bit ev;
        sb = '{2, 4, 5, 10, 13};
        sw = '{3, 4, 7, 11, 13};
        for (int s = 1; s <= 14; s++) begin
            if (s <= 5) begin
                en = 1'b1; drive(1'b1, 8'(sb[s-1]), 8'(sw[s-1]), 8'(s));
            end else if (s <= 8) begin
                en = 1'b0; drive(1'b1, 8'hEE, 8'hEE, 8'hEE);
            end else begin
                en = 1'b1; drive(1'b0, 8'd0, 8'd0, 8'd0);
            end
            step();
            ev  = (s >= 5 && s <= 12);
            idx = (s <= 8) ? 0 : s - 8;
            checks++;
            if (vc !== ev) begin errors++; $display("FAIL stall_valid cyc=%0d got=%b want=%b", s, vc, ev); end
            if (ev) begin
                checks++;
                if (bwc !== 8'((sb[idx] * sw[idx]) % 17) || ac !== 8'(idx + 1)) begin
                    errors++; $display("FAIL stall_data cyc=%0d got bw=%0d a=%0d want bw=%0d a=%0d",
                                       s, bwc, ac, (sb[idx] * sw[idx]) % 17, idx + 1);
                end
            end
        end
        en = 1'b1;
    endtask

    task automatic test_runtime_q();
        int idx;
        drive(1'b1, 8'd3, 8'd5, 8'd9);
        step();
        drive(1'b0, 8'd0, 8'd0, 8'd0);
        for (int c = 2; c <= 6; c++) begin
            step();
            checks++;
            if (vr !== (c == 5)) begin errors++; $display("FAIL rtq_basic_valid cyc=%0d got=%b want=%b", c, vr, (c == 5)); end
            if (c == 5) begin
                checks++;
                if (bwr !== 8'd15 || ar !== 8'd9) begin
                    errors++; $display("FAIL rtq_basic_data got bw=%0d a=%0d want bw=15 a=9", bwr, ar);
                end
            end
        end
        for (int c = 1; c <= 25; c++) begin
            if (c <= 17) drive(1'b1, 8'(c - 1), 8'(c - 1), 8'(c - 1));
            else         drive(1'b0, 8'd0, 8'd0, 8'd0);
            step();
            idx = c - 5;
            checks++;
            if (vr !== (c >= 5 && c <= 21)) begin
                errors++; $display("FAIL rtq_b2b_valid cyc=%0d got=%b want=%b", c, vr, (c >= 5 && c <= 21));
            end
            if (c >= 5 && c <= 21) begin
                checks++;
                if (bwr !== 8'((idx * idx) % 17) || ar !== 8'(idx)) begin
                    errors++; $display("FAIL rtq_b2b_data i=%0d got bw=%0d a=%0d want bw=%0d a=%0d",
                                       idx, bwr, ar, (idx * idx) % 17, idx);
                end
            end
        end
    endtask

    task automatic test_reset_midstream();
        drive(1'b1, 8'd3, 8'd5, 8'd9); step();
        drive(1'b1, 8'd4, 8'd4, 8'd2); step();
        drive(1'b1, 8'd5, 8'd7, 8'd3); step();
        drive(1'b0, 8'd0, 8'd0, 8'd0); step();
        rst = 1'b1; step();
        checks++;
        if (vc !== 1'b0 || ac !== 8'd0 || bwc !== 8'd0) begin
            errors++; $display("FAIL rst_mid_c got v=%b a=%0d bw=%0d want 0 0 0", vc, ac, bwc);
        end
        checks++;
        if (vr !== 1'b0 || ar !== 8'd0 || bwr !== 8'd0) begin
            errors++; $display("FAIL rst_mid_r got v=%b a=%0d bw=%0d want 0 0 0", vr, ar, bwr);
        end
        rst = 1'b0;
        for (int s = 6; s <= 10; s++) begin
            step();
            checks++;
            if (vc !== 1'b0 || vr !== 1'b0) begin
                errors++; $display("FAIL rst_ghost cyc=%0d got vc=%b vr=%b want 0", s, vc, vr);
            end
        end
        drive(1'b1, 8'd7, 8'd9, 8'd12); step();
        drive(1'b0, 8'd0, 8'd0, 8'd0);
        for (int s = 12; s <= 15; s++) begin
            step();
            checks++;
            if (vc !== (s == 15) || vr !== (s == 15)) begin
                errors++; $display("FAIL rst_new_valid cyc=%0d got vc=%b vr=%b want %b", s, vc, vr, (s == 15));
            end
        end
        checks++;
        if (bwc !== 8'd12 || ac !== 8'd12 || bwr !== 8'd12 || ar !== 8'd12) begin
            errors++; $display("FAIL rst_new_data got bwc=%0d ac=%0d bwr=%0d ar=%0d want 12", bwc, ac, bwr, ar);
        end
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; qh = 4'h1; qh_junk = 4'hA;
        drive(1'b0, 8'd0, 8'd0, 8'd0);
        test_reset();
        test_basic();
        test_edges();
        test_back_to_back();
        test_stall();
        test_runtime_q();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
